// File: rtl/twofish_cbc_ctrl_if.sv
// Stream bundle between the host FIFO side and twofish_cbc_ctrl.
//   in_valid / in_ready / in_block    : 128-bit input block stream
//   out_valid / out_ready / out_block : 128-bit result stream
// Modports:
//   master : host/testbench side (drives input stream, accepts results)
//   slave  : controller side
interface twofish_cbc_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid,
        output in_block,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_block
    );

    modport slave (
        input  in_valid,
        input  in_block,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_block
    );
endinterface

// File: rtl/twofish_cbc_ctrl.sv
// twofish_cbc_ctrl
// Initiator-side sequencer for a Twofish datapath core. Accepts one 128-bit
// block at a time, applies ECB or CBC chaining around the core, pulses the
// core's Reset then Start, waits for busy to rise and fall, and presents the
// result on an output stream. One block in flight at a time.
//
// Ports:
//   clk, rst_n     system clock (rising edge), async active-low reset
//   bus            stream interface (slave modport): in_* / out_*
//   cfg_load       1-cycle pulse, latches cfg_* (honoured in IDLE only)
//   cfg_key        cipher key
//   cfg_iv         CBC initial chaining value
//   cfg_ende       0 = encrypt, 1 = decrypt
//   cfg_cbc        1 = CBC, 0 = ECB
//   err_timeout    sticky timeout flag, cleared by reset or cfg_load
//   core_reset     Reset pulse to the datapath
//   core_start     Start pulse to the datapath
//   core_ende      EnDe to the datapath
//   core_block     block to the datapath
//   core_key       key to the datapath
//   core_o         result from the datapath
//   core_busy      busy from the datapath
//
// State     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a block or a configuration load
// RST       | core_reset high for one cycle
// START     | core_start high for one cycle, timeout budget loaded
// WAIT_HI   | waiting for core_busy to rise
// WAIT_LO   | waiting for core_busy to fall, then capture result
// OUT       | out_valid high until out_ready
module twofish_cbc_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    twofish_cbc_ctrl_if.slave bus,
    input  logic          cfg_load,
    input  logic [127:0]  cfg_key,
    input  logic [127:0]  cfg_iv,
    input  logic          cfg_ende,
    input  logic          cfg_cbc,
    output logic          err_timeout,
    output logic          core_reset,
    output logic          core_start,
    output logic          core_ende,
    output logic [127:0]  core_block,
    output logic [127:0]  core_key,
    input  logic [127:0]  core_o,
    input  logic          core_busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST     = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t        state;
    logic [127:0]  key_q;
    logic [127:0]  chain_q;
    logic [127:0]  sav_q;
    logic          ende_q;
    logic          cbc_q;
    logic          rdy_q;
    logic          out_valid_q;
    logic [127:0]  out_block_q;
    logic [TW-1:0] tmr_q;

    // cfg_load takes priority over an incoming block, so ready is withdrawn
    // in the same cycle to keep the handshake honest.
    assign bus.in_ready  = rdy_q & ~cfg_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;

    logic [127:0] chain_mask;
    assign chain_mask = cbc_q ? chain_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_q       <= '0;
            chain_q     <= '0;
            sav_q       <= '0;
            ende_q      <= 1'b0;
            cbc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
            tmr_q       <= '0;
            err_timeout <= 1'b0;
            core_reset  <= 1'b0;
            core_start  <= 1'b0;
            core_ende   <= 1'b0;
            core_block  <= '0;
            core_key    <= '0;
        end else begin
            core_reset <= 1'b0;
            core_start <= 1'b0;

            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (cfg_load) begin
                        key_q       <= cfg_key;
                        chain_q     <= cfg_iv;
                        ende_q      <= cfg_ende;
                        cbc_q       <= cfg_cbc;
                        err_timeout <= 1'b0;
                    end else if (rdy_q && bus.in_valid) begin
                        sav_q      <= bus.in_block;
                        // Encrypt whitens the plaintext with the chain before
                        // the core; decrypt feeds the ciphertext straight in.
                        core_block <= ende_q ? bus.in_block
                                             : (bus.in_block ^ chain_mask);
                        core_key   <= key_q;
                        core_ende  <= ende_q;
                        core_reset <= 1'b1;
                        rdy_q      <= 1'b0;
                        state      <= RST;
                    end
                end

                RST: begin
                    core_start <= 1'b1;
                    state      <= START;
                end

                START: begin
                    tmr_q <= TMR_LOAD;
                    state <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (tmr_q == '0) begin
                        err_timeout <= 1'b1;
                        rdy_q       <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                        if (core_busy) begin
                            state <= WAIT_LO;
                        end
                    end
                end

                WAIT_LO: begin
                    if (!core_busy) begin
                        if (ende_q) begin
                            out_block_q <= core_o ^ chain_mask;
                            if (cbc_q) begin
                                chain_q <= sav_q;
                            end
                        end else begin
                            out_block_q <= core_o;
                            if (cbc_q) begin
                                chain_q <= core_o;
                            end
                        end
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end else if (tmr_q == '0) begin
                        // Block is dropped: no result, chain untouched.
                        err_timeout <= 1'b1;
                        rdy_q       <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end

                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twofish_cbc_ctrl.sv
module tb_twofish_cbc_ctrl;

    localparam logic [127:0] KV1  = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
    localparam logic [127:0] KV2  = 128'hD491DB16E7B1C39E86CB086B789F5419;
    localparam logic [127:0] TOYC = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_load = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         cfg_ende = 1'b0;
    logic         cfg_cbc = 1'b0;
    logic         err_timeout;
    logic         core_reset;
    logic         core_start;
    logic         core_ende;
    logic [127:0] core_block;
    logic [127:0] core_key;
    logic [127:0] core_o;
    logic         core_busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    always #5 clk = ~clk;

    twofish_cbc_ctrl_if bus();

    twofish_cbc_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg_load   (cfg_load),
        .cfg_key    (cfg_key),
        .cfg_iv     (cfg_iv),
        .cfg_ende   (cfg_ende),
        .cfg_cbc    (cfg_cbc),
        .err_timeout(err_timeout),
        .core_reset (core_reset),
        .core_start (core_start),
        .core_ende  (core_ende),
        .core_block (core_block),
        .core_key   (core_key),
        .core_o     (core_o),
        .core_busy  (core_busy)
    );

    // Stand-in cipher: the two published key=0 Twofish vectors, and an
    // invertible toy transform for everything else.
    function automatic logic [127:0] cipher_e(input logic [127:0] k, input logic [127:0] x);
        logic [127:0] t;
        if (k == '0 && x == '0) return KV1;
        if (k == '0 && x == KV1) return KV2;
        t = x ^ k;
        return {t[63:0], t[127:64]} ^ TOYC;
    endfunction

    function automatic logic [127:0] cipher_d(input logic [127:0] k, input logic [127:0] y);
        logic [127:0] t;
        if (k == '0 && y == KV1) return '0;
        if (k == '0 && y == KV2) return KV1;
        t = y ^ TOYC;
        return {t[63:0], t[127:64]} ^ k;
    endfunction

    // Behavioural core: random delay before busy rises, random busy length.
    logic         stuck = 1'b0;
    logic         busy_q;
    logic [127:0] o_q;
    logic [127:0] res_q;
    int           ph;
    int           pre;
    int           lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            o_q    <= '0;
            res_q  <= '0;
            ph     <= 0;
            pre    <= 0;
            lat    <= 0;
        end else if (core_reset) begin
            busy_q <= 1'b0;
            ph     <= 0;
        end else begin
            case (ph)
                0: if (core_start) begin
                    res_q <= core_ende ? cipher_d(core_key, core_block)
                                       : cipher_e(core_key, core_block);
                    pre   <= int'($urandom_range(0, 3));
                    ph    <= 1;
                end
                1: if (pre == 0) begin
                    busy_q <= 1'b1;
                    lat    <= int'($urandom_range(1, 10));
                    ph     <= 2;
                end else begin
                    pre <= pre - 1;
                end
                default: if (lat == 0) begin
                    busy_q <= 1'b0;
                    o_q    <= res_q;
                    ph     <= 0;
                end else begin
                    lat <= lat - 1;
                end
            endcase
        end
    end

    assign core_busy = stuck | busy_q;
    assign core_o    = o_q;

    always @(negedge clk) begin
        if (core_start) starts++;
    end

    // Reference model: textbook ECB/CBC over the stand-in cipher.
    logic [127:0] m_key = '0;
    logic [127:0] m_chain = '0;
    logic         m_ende = 1'b0;
    logic         m_cbc = 1'b0;
    logic [127:0] expq[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_block(input logic [127:0] p);
        logic [127:0] r;
        if (!m_ende) begin
            r = cipher_e(m_key, m_cbc ? (p ^ m_chain) : p);
            if (m_cbc) m_chain = r;
        end else begin
            r = cipher_d(m_key, p);
            if (m_cbc) begin
                r = r ^ m_chain;
                m_chain = p;
            end
        end
        expq.push_back(r);
    endtask

    task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic e, input logic c);
        @(negedge clk);
        cfg_key = k; cfg_iv = iv; cfg_ende = e; cfg_cbc = c; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        m_key = k; m_chain = iv; m_ende = e; m_cbc = c;
    endtask

    task automatic send(input logic [127:0] p, input bit expect_out);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_block = p;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_seen", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (expect_out) model_block(p);
    endtask

    task automatic recv(input int hold);
        int n;
        logic [127:0] held;
        logic [127:0] e;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        e = (expq.size() > 0) ? expq.pop_front() : 128'hDEAD;
        held = bus.out_block;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", bus.out_block, held);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_valid", bus.out_valid, 1);
        end
        check("out_block", bus.out_block, e);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_in_ready"},   bus.in_ready, 0);
        check({pfx, "_out_valid"},  bus.out_valid, 0);
        check({pfx, "_out_block"},  bus.out_block, 0);
        check({pfx, "_err"},        err_timeout, 0);
        check({pfx, "_core_reset"}, core_reset, 0);
        check({pfx, "_core_start"}, core_start, 0);
        check({pfx, "_core_ende"},  core_ende, 0);
        check({pfx, "_core_block"}, core_block, 0);
        check({pfx, "_core_key"},   core_key, 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        logic [127:0] ka;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;

        #2;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_in_ready", bus.in_ready, 1);

        // 1: ECB encrypt, single core_start pulse
        do_cfg('0, '0, 1'b0, 1'b0);
        s0 = starts;
        send('0, 1'b1);
        recv(0);
        check("t1_start_pulses", 128'(starts - s0), 1);

        // 2: ECB decrypt
        do_cfg('0, '0, 1'b1, 1'b0);
        send(KV1, 1'b1);
        recv(0);

        // 3: CBC encrypt two zero blocks
        do_cfg('0, '0, 1'b0, 1'b1);
        send('0, 1'b1); recv(0);
        send('0, 1'b1); recv(0);

        // 4: CBC decrypt with back-pressure on the first result
        do_cfg('0, '0, 1'b1, 1'b1);
        send(KV1, 1'b1); recv(10);
        send(KV2, 1'b1); recv(0);

        // cfg_load and in_valid together: the load wins, nothing starts
        @(negedge clk);
        ka = rnd128();
        cfg_key = ka; cfg_iv = '0; cfg_ende = 1'b0; cfg_cbc = 1'b0;
        cfg_load = 1'b1;
        bus.in_valid = 1'b1; bus.in_block = rnd128();
        s0 = starts;
        #1;
        check("collide_in_ready", bus.in_ready, 0);
        @(negedge clk);
        cfg_load = 1'b0; bus.in_valid = 1'b0;
        m_key = ka; m_chain = '0; m_ende = 1'b0; m_cbc = 1'b0;
        repeat (6) @(negedge clk);
        check("collide_no_start", 128'(starts - s0), 0);
        check("collide_ready_back", bus.in_ready, 1);

        // 5: timeout with a stuck-busy core, chain preserved across the drop
        do_cfg(rnd128(), rnd128(), 1'b0, 1'b1);
        send(rnd128(), 1'b1); recv(0);
        stuck = 1'b1;
        send(rnd128(), 1'b0);
        n = 0;
        while (!core_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_start_seen", core_start, 1);
        repeat (64) @(negedge clk);
        check("t5_err_early", err_timeout, 0);
        @(negedge clk);
        check("t5_err_set", err_timeout, 1);
        check("t5_idle_ready", bus.in_ready, 1);
        check("t5_no_out", bus.out_valid, 0);
        stuck = 1'b0;
        send(rnd128(), 1'b1); recv(1);
        check("t5_err_sticky", err_timeout, 1);
        do_cfg(rnd128(), rnd128(), 1'b1, 1'b1);
        check("t5_err_cleared", err_timeout, 0);
        send(rnd128(), 1'b1); recv(0);

        // randomized configurations and blocks
        for (int c = 0; c < 6; c++) begin
            do_cfg(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int b = 0; b < 4; b++) begin
                send(rnd128(), 1'b1);
                recv(int'($urandom_range(0, 3)));
            end
        end

        // 6: reset during WAIT_LO, then re-run test 3
        do_cfg(rnd128(), rnd128(), 1'b0, 1'b1);
        stuck = 1'b1;
        send(rnd128(), 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        stuck = 1'b0;
        m_key = '0; m_chain = '0; m_ende = 1'b0; m_cbc = 1'b0;
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_cfg('0, '0, 1'b0, 1'b1);
        send('0, 1'b1); recv(0);
        send('0, 1'b1); recv(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
